// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan controller: default slot timing,
// per-slot state encoding and the width of one hex digit field.
package seg7_pkg;

    localparam int DW       = 4;      // bits per displayed digit (one hex nibble)
    localparam int DIV_DEF  = 27000;  // cycles per digit slot, 1 ms at 27 MHz
    localparam int DEAD_DEF = 270;    // blank cycles at the start of each slot

    // Per-slot state: dark dead-time first, then the digit is lit
    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_SHOW  = 1'b1;

endpackage

// File: rtl/seg7_slot_timer.sv
// Slot timer for the scan controller. Owns the in-slot counter and the digit
// index, and exposes both the current and next-cycle show/idx so the parent
// can register its digit enables without a decode glitch.
// DEAD must be at least 1 (reset state is BLANK) and DIV at least DEAD+2.
module seg7_slot_timer
    import seg7_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int DIV    = DIV_DEF,
    parameter int DEAD   = DEAD_DEF,
    parameter int IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    output logic          show,
    output logic [IW-1:0] idx,
    output logic          boundary,
    output logic          show_nxt,
    output logic [IW-1:0] idx_nxt
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [CW-1:0] cnt, cnt_nxt;
    logic [0:0]    st, st_nxt;
    logic          last;

    // Next-state for counter, digit index and BLANK/SHOW state
    always_comb begin
        last     = (cnt == CNT_LAST);
        boundary = last && (idx == IDX_LAST);
        cnt_nxt  = last ? '0 : cnt + 1'b1;
        idx_nxt  = idx;
        if (last) idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        st_nxt   = (cnt_nxt >= CNT_DEAD) ? ST_SHOW : ST_BLANK;
        show_nxt = (st_nxt == ST_SHOW);
    end

    assign show = (st == ST_SHOW);

    // Slot registers; state is held alongside cnt so show never decodes live
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
            st  <= ST_BLANK;
        end else begin
            cnt <= cnt_nxt;
            idx <= idx_nxt;
            st  <= st_nxt;
        end
    end

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed scan controller for a common-cathode multi-digit 7-segment
// display. Drives the shared hex decoder nibble, one-hot digit enables and the
// decimal point, with a blank dead-time at the start of every digit slot.
// New values are taken over valid/ready into a pending buffer and swapped in
// only at a frame boundary so a frame never mixes old and new digits.
// Optional feature: define SEG7_SCAN_LZB_EN for leading-zero blanking.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int DIV    = DIV_DEF,
    parameter int DEAD   = DEAD_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [DW*DIGITS-1:0] wr_data,
    input  logic [DIGITS-1:0]    wr_dp,
    output logic [DW-1:0]        nib,
    output logic                 dp,
    output logic [DIGITS-1:0]    dig_en,
    output logic                 frame_start
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [DIGITS-1:0][DW-1:0] act, pend, act_nxt;
    logic [DIGITS-1:0]         act_dp, pend_dp, act_dp_nxt;
    logic                      pf, accept, commit;
    logic                      show, show_nxt, boundary;
    logic [IW-1:0]             idx, idx_nxt;
    logic [DIGITS-1:0]         vis, sel_nxt, en_nxt;

    seg7_slot_timer #(
        .DIGITS (DIGITS),
        .DIV    (DIV),
        .DEAD   (DEAD),
        .IW     (IW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .show     (show),
        .idx      (idx),
        .boundary (boundary),
        .show_nxt (show_nxt),
        .idx_nxt  (idx_nxt)
    );

    assign wr_ready   = ~pf;
    assign accept     = wr_valid & ~pf;
    // A write landing on the boundary edge sees pf=0 here, so it waits a frame
    assign commit     = boundary & pf;
    assign act_nxt    = commit ? pend    : act;
    assign act_dp_nxt = commit ? pend_dp : act_dp;

    // Nibble and dp follow the current slot; only the enables need to be clean
    assign nib = act[idx];
    assign dp  = show & act_dp[idx];

`ifdef SEG7_SCAN_LZB_EN
    // Show a digit if any digit at or above it is nonzero, it has a dp, or it is digit 0
    always_comb begin
        logic keep;
        keep = 1'b0;
        vis  = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            keep   = keep | (|act_nxt[i]);
            vis[i] = keep | act_dp_nxt[i] | (i == 0);
        end
    end
`else
    assign vis = '1;
`endif

    // Enables for the coming cycle, built from next-state so they can be registered
    always_comb begin
        sel_nxt          = '0;
        sel_nxt[idx_nxt] = 1'b1;
        en_nxt           = show_nxt ? (sel_nxt & vis) : '0;
    end

    // Display buffers, handshake flag and registered enables / frame pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act         <= '0;
            act_dp      <= '0;
            pend        <= '0;
            pend_dp     <= '0;
            pf          <= 1'b0;
            dig_en      <= '0;
            frame_start <= 1'b0;
        end else begin
            act    <= act_nxt;
            act_dp <= act_dp_nxt;
            if (accept) begin
                pend    <= wr_data;
                pend_dp <= wr_dp;
            end
            pf          <= accept | (pf & ~commit);
            dig_en      <= en_nxt;
            frame_start <= boundary;
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan with DIGITS=4, DIV=8, DEAD=2. Each phase starts from
// reset so cycle numbers match the post-reset count. A frame model and a
// scoreboard of accepted writes are checked every cycle, alongside a table
// of hand-derived expectations over cycle ranges.
module tb_seg7_scan;

    localparam int DIGITS = 4, DIV = 8, DEAD = 2, FRAME = DIGITS * DIV;
    localparam logic [4:0] M_EN = 5'd1, M_NIB = 5'd2, M_DP = 5'd4, M_RDY = 5'd8, M_FS = 5'd16;

    logic        clk = 1'b0, rst = 1'b1, wr_valid = 1'b0;
    logic [15:0] wr_data = '0;
    logic [3:0]  wr_dp = '0;
    logic        wr_ready, dp, frame_start;
    logic [3:0]  nib, dig_en;

    int cyc;
    int n_chk = 0, n_fail = 0;

    typedef struct {
        int lo, hi; logic [4:0] m;
        logic [3:0] en, nib; logic dp, rdy, fs; string nm;
    } exp_t;
    typedef struct { int c; logic [15:0] v; logic [3:0] d; } wr_t;
    typedef struct { logic [15:0] v; logic [3:0] d; int start; } sb_t;

    exp_t ev[$];
    wr_t  wv[$];
    sb_t  sb[$];
    logic [15:0] cur_v;
    logic [3:0]  cur_d;
    logic acc;
    int   acc_cyc;

    seg7_scan #(.DIGITS(DIGITS), .DIV(DIV), .DEAD(DEAD)) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_data(wr_data), .wr_dp(wr_dp), .nib(nib), .dp(dp),
        .dig_en(dig_en), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst)
        if (rst) cyc <= 0; else cyc <= cyc + 1;

    function automatic exp_t E(input int lo, hi, input logic [4:0] m, input logic [3:0] en, nb,
                               input logic d, r, f, input string nm);
        exp_t e;
        e.lo = lo; e.hi = hi; e.m = m; e.en = en; e.nib = nb; e.dp = d; e.rdy = r; e.fs = f; e.nm = nm;
        return e;
    endfunction

    function automatic wr_t W(input int c, input logic [15:0] v, input logic [3:0] d);
        wr_t w;
        w.c = c; w.v = v; w.d = d;
        return w;
    endfunction

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, a, e);
        end
    endtask

    task automatic drive();
        if (wv.size() > 0 && wv[0].c <= cyc) begin
            wr_valid = 1'b1; wr_data = wv[0].v; wr_dp = wv[0].d;
        end else begin
            wr_valid = 1'b0;
        end
    endtask

    task automatic sample();
        int slot, ph;
        logic [3:0] vis, een;
        logic show;
        slot = (cyc / DIV) % DIGITS;
        ph   = cyc % DIV;
        if (cyc % FRAME == 0 && cyc > 0)
            while (sb.size() > 0 && sb[0].start <= cyc) begin
                cur_v = sb[0].v; cur_d = sb[0].d; sb.delete(0);
            end
        vis = '1;
`ifdef SEG7_SCAN_LZB_EN
        for (int i = 0; i < DIGITS; i++)
            vis[i] = (i == 0) || cur_d[i] || ((cur_v >> (4 * i)) != 16'h0);
`endif
        show = (ph >= DEAD);
        een  = '0;
        if (show && vis[slot]) een[slot] = 1'b1;
        chk("model", {dig_en, nib, dp, wr_ready, frame_start},
            {een, cur_v[slot*4 +: 4], show & cur_d[slot], sb.size() == 0, (cyc % FRAME == 0) && (cyc > 0)});
        foreach (ev[i]) if (cyc >= ev[i].lo && cyc <= ev[i].hi) begin
            if (ev[i].m[0]) chk({ev[i].nm, "_en"},  dig_en,      ev[i].en);
            if (ev[i].m[1]) chk({ev[i].nm, "_nib"}, nib,         ev[i].nib);
            if (ev[i].m[2]) chk({ev[i].nm, "_dp"},  dp,          ev[i].dp);
            if (ev[i].m[3]) chk({ev[i].nm, "_rdy"}, wr_ready,    ev[i].rdy);
            if (ev[i].m[4]) chk({ev[i].nm, "_fs"},  frame_start, ev[i].fs);
        end
        acc = wr_valid && wr_ready;
        acc_cyc = cyc;
    endtask

    // An accepted write is due on screen the cycle after the next boundary strictly after it
    task automatic post_edge();
        if (acc) begin
            int b;
            b = (acc_cyc % FRAME == FRAME - 1) ? acc_cyc + FRAME : acc_cyc + (FRAME - 1 - acc_cyc % FRAME);
            sb.push_back('{wv[0].v, wv[0].d, b + 1});
            wv.delete(0);
            acc = 1'b0;
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            drive();
            @(negedge clk);
            sample();
            @(posedge clk);
            #1;
            post_edge();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; wr_valid = 1'b0;
        wv.delete(); sb.delete(); ev.delete();
        cur_v = '0; cur_d = '0; acc = 1'b0;
        @(negedge clk);
        chk("rst_out", {dig_en, nib, dp, wr_ready, frame_start}, {4'b0, 4'h0, 1'b0, 1'b1, 1'b0});
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        // Reset and idle scan timing
        do_reset();
        ev.push_back(E(0, 1, M_EN | M_NIB | M_DP, 4'b0000, 4'h0, 0, 1, 0, "a_blank0"));
        ev.push_back(E(2, 7, M_EN, 4'b0001, 4'h0, 0, 1, 0, "a_show0"));
        ev.push_back(E(8, 9, M_EN, 4'b0000, 4'h0, 0, 1, 0, "a_blank1"));
        ev.push_back(E(10, 15, M_EN, 4'b0010, 4'h0, 0, 1, 0, "a_show1"));
        ev.push_back(E(0, 31, M_FS | M_RDY, 4'b0, 4'h0, 0, 1, 0, "a_nofs"));
        run(40);

        // Write 0x1234 then a held 0xAAAA that stalls until the first commit
        do_reset();
        wv.push_back(W(5, 16'h1234, 4'b0001));
        wv.push_back(W(6, 16'hAAAA, 4'b0000));
        ev.push_back(E(6, 31, M_RDY, 4'b0, 4'h0, 0, 0, 0, "b_stall"));
        ev.push_back(E(32, 32, M_RDY | M_FS, 4'b0, 4'h0, 0, 1, 1, "b_commit"));
        ev.push_back(E(33, 63, M_RDY, 4'b0, 4'h0, 0, 0, 0, "b_stall2"));
        ev.push_back(E(34, 39, M_EN | M_NIB | M_DP, 4'b0001, 4'h4, 1, 0, 0, "b_d0"));
        ev.push_back(E(58, 63, M_EN | M_NIB, 4'b1000, 4'h1, 0, 0, 0, "b_d3"));
        ev.push_back(E(66, 71, M_EN | M_NIB | M_DP, 4'b0001, 4'hA, 0, 0, 0, "b_f3"));
        run(100);

        // Write on the boundary edge waits a whole frame
        do_reset();
        wv.push_back(W(31, 16'h5555, 4'b0000));
        ev.push_back(E(34, 39, M_EN | M_NIB, 4'b0001, 4'h0, 0, 0, 0, "c_old"));
        ev.push_back(E(32, 63, M_RDY, 4'b0, 4'h0, 0, 0, 0, "c_pend"));
        ev.push_back(E(64, 64, M_NIB | M_RDY | M_FS, 4'b0, 4'h5, 0, 1, 1, "c_new"));
        ev.push_back(E(66, 71, M_EN | M_NIB, 4'b0001, 4'h5, 0, 0, 0, "c_show"));
        run(80);

        // Asynchronous reset in the middle of SHOW with a write pending
        do_reset();
        wv.push_back(W(5, 16'h1234, 4'b0001));
        wv.push_back(W(6, 16'h9999, 4'b0000));
        ev.push_back(E(34, 35, M_EN | M_NIB | M_DP | M_RDY, 4'b0001, 4'h4, 1, 0, 0, "d_pre"));
        run(36);
        chk("d_show36", dig_en, 4'b0001);
        #2 rst = 1'b1;
        #1 chk("d_async", {dig_en, nib, dp, wr_ready, frame_start}, {4'b0, 4'h0, 1'b0, 1'b1, 1'b0});
        do_reset();
        ev.push_back(E(34, 39, M_EN | M_NIB | M_DP, 4'b0001, 4'h0, 0, 1, 0, "d_lost"));
        ev.push_back(E(32, 32, M_RDY | M_FS, 4'b0, 4'h0, 0, 1, 1, "d_fs"));
        run(70);

        // Leading-zero blanking with 0x0070
        do_reset();
        wv.push_back(W(0, 16'h0070, 4'b0000));
        ev.push_back(E(34, 39, M_EN | M_NIB, 4'b0001, 4'h0, 0, 0, 0, "e_d0"));
        ev.push_back(E(42, 47, M_EN | M_NIB, 4'b0010, 4'h7, 0, 0, 0, "e_d1"));
`ifdef SEG7_SCAN_LZB_EN
        ev.push_back(E(50, 55, M_EN | M_NIB, 4'b0000, 4'h0, 0, 0, 0, "e_d2"));
        ev.push_back(E(58, 63, M_EN | M_NIB, 4'b0000, 4'h0, 0, 0, 0, "e_d3"));
`else
        ev.push_back(E(50, 55, M_EN | M_NIB, 4'b0100, 4'h0, 0, 0, 0, "e_d2"));
        ev.push_back(E(58, 63, M_EN | M_NIB, 4'b1000, 4'h0, 0, 0, 0, "e_d3"));
`endif
        run(70);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_scan.md
# seg7_scan

Time-multiplexed scan controller for a multi-digit common-cathode 7-segment display. It sequences the shared 4-bit hex-to-segment decoder across DIGITS digit positions. It drives the decoder's nibble input, one-hot digit enables and decimal point, with a dead-time blank between digits to suppress ghosting. New display values arrive over a valid/ready handshake and are committed only at frame boundaries, so a frame never mixes old and new values.

## Interface
- DIGITS, 4, number of digit positions (2..8)
- DIV, 27000, clock cycles per digit slot (1 ms at 27 MHz); must be ≥ DEAD+2
- DEAD, 270, blank cycles at the start of each slot
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- wr_valid  in  1  new display value offered
- wr_ready  out  1  pending buffer empty; value accepted when wr_valid & wr_ready at a rising edge
- wr_data  in  4*DIGITS  digit i = wr_data[4i+3:4i]; digit 0 is rightmost
- wr_dp  in  DIGITS  decimal point per digit
- nib  out  4  nibble to the hex decoder
- dp  out  1  decimal point segment, active-high
- dig_en  out  DIGITS  one-hot digit enable, active-high; all zero while blanking
- frame_start  out  1  one-cycle pulse, first cycle of each new frame

## Operation
- Registers: slot counter cnt (0..DIV-1), digit index idx (0..DIGITS-1), active value/dp, pending value/dp, pending-full flag pf.
- Per-slot states: BLANK while cnt < DEAD; SHOW while cnt ≥ DEAD.
- BLANK: dig_en = 0 and dp = 0.
- SHOW: dig_en = 1<<idx and dp = active_dp[idx].
- nib = active digit idx in both states.
- cnt == DIV-1: cnt→0, and idx→idx+1, wrapping DIGITS-1→0. Otherwise cnt increments.
- Frame boundary is idx == DIGITS-1 & cnt == DIV-1. At that edge, if pf: active ← pending, pf ← 0. frame_start is registered high for the following cycle.
- wr_ready = ~pf (combinational from the register). An accepted write loads pending and sets pf.
- A write accepted on the boundary edge itself lands in pending. It is committed at the next boundary, not the current one.
- While pf = 1, further writes stall. wr_valid/wr_data must stay stable until accepted.
- Reset asserted at any time, including mid-SHOW:
  - immediately: cnt = 0, idx = 0, active = 0, active_dp = 0, pf = 0, pending discarded;
  - outputs: dig_en = 0, dp = 0, nib = 0, frame_start = 0, wr_ready = 1.
- The first frame after reset displays zeros. frame_start does not pulse for it.

## Timing
- Frame period: DIGITS*DIV cycles.
- Post-reset cycle 0 has cnt = 0, idx = 0.
- Write-to-display latency: from acceptance to the next boundary plus 1 cycle; worst case DIGITS*DIV cycles.
- dig_en is registered-equivalent: it changes only on clk edges and has no glitches between BLANK and SHOW.

## Configuration
- SEG7_SCAN_LZB_EN defined (leading-zero blanking):
  - During SHOW, dig_en stays 0 for every digit position above the highest nonzero active digit.
  - Digit 0 is always shown.
  - A digit with active_dp set is always shown.
  - nib is unaffected.
- SEG7_SCAN_LZB_EN undefined: every digit is enabled in its SHOW window.

## Structure
- Shared package seg7_pkg:
  - default DIV/DEAD constants;
  - BLANK/SHOW state encoding;
  - digit-field width constant (4).
- One sub-module, seg7_slot_timer: owns cnt and idx, and outputs show, idx and the boundary strobe. The parent owns the buffers, handshake and LZB logic.
- The hex decoder is instantiated outside this block, fed from nib.

## Test plan
Use DIGITS=4, DIV=8, DEAD=2 for all scenarios.
- Reset check:
  - during rst: dig_en=0000, nib=0, dp=0, wr_ready=1, frame_start=0;
  - after release: cycles 0–1 dig_en=0000, cycles 2–7 dig_en=0001, cycles 10–15 dig_en=0010.
- Write 0x1234 with dp=0001 in cycle 5:
  - wr_ready=0 in cycles 6–31; frame_start=1 in cycle 32;
  - in cycles 34–39, dig_en=0001, nib=4, dp=1;
  - in cycles 58–63, dig_en=1000, nib=1.
- Back-to-back writes:
  - hold wr_valid with 0xAAAA in cycle 6;
  - it is accepted in cycle 32; 0x1234 is shown in frame 2 and 0xAAAA in frame 3 (from cycle 64).
- Write 0x5555 in cycle 31 (boundary edge): frame 2 still shows 0; nib=5 from cycle 64.
- Reset mid-operation:
  - assert rst in cycle 36 (SHOW, digit 0);
  - dig_en=0 within the same cycle (asynchronous); after release the display shows 0 and the pending write is lost.
- LZB with value 0x0070:
  - with SEG7_SCAN_LZB_EN: digits 3 and 2 are never enabled, digit 1 shows 7, digit 0 shows 0;
  - without the macro: all four digits are enabled.
